// File: rtl/axis_test_pkg.sv
// Shared constants and helpers for the AXI-Stream loopback test path:
// counting pattern, checker states and throttle LFSR definition.
package axis_test_pkg;

    localparam logic [23:0] PAT_HI    = 24'hAAAAAA;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5 feed bit 15)
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        OFF,
        SOF,
        BODY
    } state_t;

    function automatic logic [31:0] expected_word(input logic [7:0] idx);
        return {PAT_HI, idx};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {^(v & LFSR_TAPS), v[15:1]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/axis_chk32.sv
// AXI-Stream sink that checks MM2S loopback frames against the counting
// pattern and keeps saturating good/bad frame and per-class error counters.
module axis_chk32
    import axis_test_pkg::*;
#(
    parameter int BYTES_PER_BLOCK = 64,
    parameter int CNT_W           = 16,
    parameter int THROTTLE        = 0
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             en,
    input  logic             clear,
    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    input  logic [3:0]       s_tkeep,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames,
    output logic [CNT_W-1:0] err_data,
    output logic [CNT_W-1:0] err_last,
    output logic [CNT_W-1:0] err_keep,
    output logic             error,
    output logic             busy
);

    localparam int          WORDS_PER_BLOCK = BYTES_PER_BLOCK / 4;
    localparam logic [15:0] LAST_IDX        = 16'(WORDS_PER_BLOCK - 1);

    state_t      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic        ferr_q, ferr_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        err_q, err_d;

    logic hs;
    logic bad_data, bad_keep, bad_last, beat_err;
    logic inc_data, inc_keep, inc_last, inc_good, inc_bad;

    assign hs = s_tvalid & s_tready;

    assign bad_data = (s_tdata != expected_word(idx_q[7:0]));
    assign bad_keep = (s_tkeep != 4'hF);
    // A missing TLAST can only fire once per frame: idx passes LAST_IDX exactly once
    assign bad_last = s_tlast ? (idx_q < LAST_IDX) : (idx_q == LAST_IDX);
    assign beat_err = bad_data | bad_keep | bad_last;

    // A coincident clear discards this beat's increments
    assign inc_data = hs & bad_data & ~clear;
    assign inc_keep = hs & bad_keep & ~clear;
    assign inc_last = hs & bad_last & ~clear;
    assign inc_good = hs & s_tlast & ~(ferr_q | beat_err) & ~clear;
    assign inc_bad  = hs & s_tlast &  (ferr_q | beat_err) & ~clear;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ferr_d  = ferr_q;
        if (!en) begin
            state_d = OFF;
            idx_d   = '0;
            ferr_d  = 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = SOF;
                    idx_d   = '0;
                    ferr_d  = 1'b0;
                end
                default: begin
                    if (hs) begin
                        if (s_tlast) begin
                            state_d = SOF;
                            idx_d   = '0;
                            ferr_d  = 1'b0;
                        end else begin
                            state_d = BODY;
                            idx_d   = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;
                            ferr_d  = ferr_q | beat_err;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        lfsr_d = ((state_q == OFF) || !en) ? LFSR_SEED : lfsr_next(lfsr_q);
        err_d  = clear ? 1'b0 : (err_q | inc_data | inc_keep | inc_last);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= OFF;
            idx_q   <= '0;
            ferr_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ferr_q  <= ferr_d;
            lfsr_q  <= lfsr_d;
            err_q   <= err_d;
        end
    end

    assign s_tready = (state_q != OFF) && ((THROTTLE == 0) || lfsr_q[0] || lfsr_q[1]);
    assign busy     = (state_q == BODY);
    assign error    = err_q;

    sat_counter #(.W(CNT_W)) u_cnt_good (
        .aclk(aclk), .aresetn(aresetn), .inc(inc_good), .clr(clear), .cnt(good_frames)
    );
    sat_counter #(.W(CNT_W)) u_cnt_bad (
        .aclk(aclk), .aresetn(aresetn), .inc(inc_bad), .clr(clear), .cnt(bad_frames)
    );
    sat_counter #(.W(CNT_W)) u_cnt_data (
        .aclk(aclk), .aresetn(aresetn), .inc(inc_data), .clr(clear), .cnt(err_data)
    );
    sat_counter #(.W(CNT_W)) u_cnt_last (
        .aclk(aclk), .aresetn(aresetn), .inc(inc_last), .clr(clear), .cnt(err_last)
    );
    sat_counter #(.W(CNT_W)) u_cnt_keep (
        .aclk(aclk), .aresetn(aresetn), .inc(inc_keep), .clr(clear), .cnt(err_keep)
    );

endmodule

// File: tb/tb_axis_chk32.sv
// Scoreboard bench for axis_chk32: one unthrottled and one throttled instance
// share the stream inputs; only the enabled one handshakes at any time.
module tb_axis_chk32;

    localparam int W    = 16;
    localparam int MAXC = 65535;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn, en0, en1, clear, tvalid, tlast;
    logic [31:0] tdata;
    logic [3:0]  tkeep;

    logic        tready0, tready1, error0, error1, busy0, busy1;
    logic [15:0] good0, bad0, ed0, el0, ek0;
    logic [15:0] good1, bad1, ed1, el1, ek1;

    bit          sel = 1'b0;
    logic        tready_m, error_m, busy_m;
    logic [15:0] good_m, bad_m, ed_m, el_m, ek_m;

    assign tready_m = sel ? tready1 : tready0;
    assign error_m  = sel ? error1  : error0;
    assign busy_m   = sel ? busy1   : busy0;
    assign good_m   = sel ? good1   : good0;
    assign bad_m    = sel ? bad1    : bad0;
    assign ed_m     = sel ? ed1     : ed0;
    assign el_m     = sel ? el1     : el0;
    assign ek_m     = sel ? ek1     : ek0;

    axis_chk32 #(.BYTES_PER_BLOCK(64), .CNT_W(16), .THROTTLE(0)) u_dut0 (
        .aclk(aclk), .aresetn(aresetn), .en(en0), .clear(clear),
        .s_tdata(tdata), .s_tvalid(tvalid), .s_tready(tready0), .s_tlast(tlast), .s_tkeep(tkeep),
        .good_frames(good0), .bad_frames(bad0), .err_data(ed0), .err_last(el0), .err_keep(ek0),
        .error(error0), .busy(busy0)
    );

    axis_chk32 #(.BYTES_PER_BLOCK(64), .CNT_W(16), .THROTTLE(1)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn), .en(en1), .clear(clear),
        .s_tdata(tdata), .s_tvalid(tvalid), .s_tready(tready1), .s_tlast(tlast), .s_tkeep(tkeep),
        .good_frames(good1), .bad_frames(bad1), .err_data(ed1), .err_last(el1), .err_keep(ek1),
        .error(error1), .busy(busy1)
    );

    int nchecks = 0;
    int nerrors = 0;
    int stall_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: counts expressed per frame position, not per RTL state
    typedef struct {
        int good;
        int bad;
        int ed;
        int el;
        int ek;
        bit err;
    } snap_t;

    snap_t sb[$];
    int m_good, m_bad, m_ed, m_el, m_ek, m_pos;
    bit m_err, m_fbad;

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic zero_counts();
        m_good = 0; m_bad = 0; m_ed = 0; m_el = 0; m_ek = 0; m_err = 0;
    endtask

    task automatic new_frame();
        m_pos = 0; m_fbad = 0;
    endtask

    task automatic model_beat(input logic [31:0] d, input bit l, input logic [3:0] k, input bit c);
        logic [31:0] ew;
        bit de, ke, le;
        snap_t s;
        ew = 32'hAAAAAA00 | 32'(m_pos % 256);
        de = (d != ew);
        ke = (k != 4'hF);
        le = l ? (m_pos < W - 1) : (m_pos == W - 1);
        if (c) begin
            zero_counts();
        end else begin
            if (de) m_ed = sat(m_ed);
            if (ke) m_ek = sat(m_ek);
            if (le) m_el = sat(m_el);
            if (de || ke || le) m_err = 1;
            if (l) begin
                if (m_fbad || de || ke || le) m_bad = sat(m_bad);
                else m_good = sat(m_good);
            end
        end
        if (l) new_frame();
        else begin
            if (m_pos < 65535) m_pos++;
            m_fbad = m_fbad | de | ke | le;
        end
        s = '{good: m_good, bad: m_bad, ed: m_ed, el: m_el, ek: m_ek, err: m_err};
        sb.push_back(s);
    endtask

    // Monitor: a handshake seen before an edge is checked on the next falling edge
    bit pend = 1'b0;
    always @(negedge aclk) begin
        snap_t s;
        if (pend) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 0, 1);
            end else begin
                s = sb.pop_front();
                chk("sb_good_frames", good_m, s.good);
                chk("sb_bad_frames", bad_m, s.bad);
                chk("sb_err_data", ed_m, s.ed);
                chk("sb_err_last", el_m, s.el);
                chk("sb_err_keep", ek_m, s.ek);
                chk("sb_error", error_m, s.err);
            end
        end
        pend = aresetn && tvalid && tready_m;
    end

    // Throttle reference: LFSR stepped per cycle while enabled, seeded while off
    bit          m_off = 1'b1;
    logic [15:0] m_lfsr = 16'hACE1;
    bit          chk_lfsr = 1'b0;
    always @(posedge aclk) begin
        if (!aresetn) begin
            m_off = 1'b1;
            m_lfsr = 16'hACE1;
        end else begin
            if (m_off || !en1) m_lfsr = 16'hACE1;
            else m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            m_off = !en1;
        end
    end
    always @(negedge aclk) begin
        if (chk_lfsr) chk("tready_lfsr", tready1, (!m_off && (m_lfsr[1:0] != 2'b00)));
    end

    task automatic beat(input logic [31:0] d, input bit l, input logic [3:0] k, input bit c,
                        input int gap);
        int guard;
        bit done;
        if (gap > 0) begin
            tvalid = 1'b0;
            repeat (gap) begin
                @(posedge aclk);
                #1;
            end
        end
        tdata = d; tlast = l; tkeep = k; clear = c; tvalid = 1'b1;
        guard = 0;
        done = 0;
        while (!done) begin
            @(negedge aclk);
            if (tready_m) begin
                model_beat(d, l, k, c);
                done = 1;
            end else begin
                stall_cnt++;
                guard++;
                if (guard > 200) begin
                    chk("tready_timeout", 0, 1);
                    done = 1;
                end
            end
            @(posedge aclk);
            #1;
        end
        clear = 1'b0;
    endtask

    task automatic send_frame(input int len, input int bad_pos, input logic [31:0] bad_val,
                              input int keep_pos, input logic [3:0] keep_val,
                              input bit clr_last, input bit gaps);
        logic [31:0] d;
        logic [3:0]  k;
        int          g;
        for (int i = 0; i < len; i++) begin
            d = 32'hAAAAAA00 | 32'(i % 256);
            if (i == bad_pos) d = bad_val;
            k = (i == keep_pos) ? keep_val : 4'hF;
            g = (gaps && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(1, 3)) : 0;
            beat(d, (i == len - 1), k, clr_last && (i == len - 1), g);
        end
    endtask

    task automatic settle();
        tvalid = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_all();
        clear = 1'b1;
        @(posedge aclk);
        #1;
        clear = 1'b0;
        zero_counts();
    endtask

    task automatic expect_counts(input string t, input int g, input int b, input int ed,
                                 input int el, input int ek, input bit e);
        chk({t, "_good_frames"}, good_m, g);
        chk({t, "_bad_frames"}, bad_m, b);
        chk({t, "_err_data"}, ed_m, ed);
        chk({t, "_err_last"}, el_m, el);
        chk({t, "_err_keep"}, ek_m, ek);
        chk({t, "_error"}, error_m, e);
    endtask

    task automatic expect_reset(input string t);
        chk({t, "_tready0"}, tready0, 0);
        chk({t, "_tready1"}, tready1, 0);
        chk({t, "_busy"}, busy0, 0);
        expect_counts(t, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  k;
        int          len;
        aresetn = 1'b0; en0 = 1'b0; en1 = 1'b0; clear = 1'b0;
        tvalid = 1'b0; tlast = 1'b0; tkeep = 4'hF; tdata = '0;
        zero_counts();
        new_frame();
        repeat (3) @(posedge aclk);
        #1;
        expect_reset("reset");
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Enable latency: ready follows en by one cycle
        en0 = 1'b1;
        @(negedge aclk);
        chk("tready_before_rise", tready0, 0);
        @(posedge aclk);
        #1;
        chk("tready_after_rise", tready0, 1);

        // Ideal stream, valid held high across frames
        stall_cnt = 0;
        repeat (3) send_frame(16, -1, 0, -1, 4'hF, 0, 0);
        settle();
        expect_counts("ideal", 3, 0, 0, 0, 0, 0);
        chk("ideal_stalls", stall_cnt, 0);
        clear_all();

        // Data error on word 5 of frame 1
        send_frame(16, -1, 0, -1, 4'hF, 0, 0);
        send_frame(16, 5, 32'hAAAAAA00, -1, 4'hF, 0, 0);
        send_frame(16, -1, 0, -1, 4'hF, 0, 0);
        settle();
        expect_counts("data_err", 2, 1, 1, 0, 0, 1);
        clear_all();

        // Early TLAST at beat 7, then TLAST missing until beat 20
        send_frame(8, -1, 0, -1, 4'hF, 0, 0);
        send_frame(21, -1, 0, -1, 4'hF, 0, 0);
        send_frame(16, -1, 0, -1, 4'hF, 0, 0);
        settle();
        expect_counts("tlast_err", 1, 2, 0, 2, 0, 1);
        clear_all();

        // Keep error, then clear coinciding with a bad last beat
        send_frame(16, -1, 0, 3, 4'h7, 0, 0);
        settle();
        expect_counts("keep_err", 0, 1, 0, 0, 1, 1);
        send_frame(16, 15, 32'h0, -1, 4'hF, 1, 0);
        settle();
        expect_counts("clear_hs", 0, 0, 0, 0, 0, 0);

        // en dropped mid-frame: partial frame is dropped
        for (int i = 0; i < 8; i++) beat(32'hAAAAAA00 | 32'(i), 1'b0, 4'hF, 1'b0, 0);
        chk("busy_mid_frame", busy0, 1);
        tvalid = 1'b0;
        en0 = 1'b0;
        @(posedge aclk);
        #1;
        chk("en_drop_tready", tready0, 0);
        chk("en_drop_busy", busy0, 0);
        new_frame();
        repeat (2) @(posedge aclk);
        #1;
        en0 = 1'b1;
        @(posedge aclk);
        #1;
        send_frame(16, -1, 0, -1, 4'hF, 0, 0);
        settle();
        expect_counts("en_drop", 1, 0, 0, 0, 0, 0);

        // Reset asserted mid-frame
        for (int i = 0; i < 5; i++) beat(32'hAAAAAA00 | 32'(i), 1'b0, 4'hF, 1'b0, 0);
        tvalid = 1'b0;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        expect_reset("mid_reset");
        aresetn = 1'b1;
        zero_counts();
        new_frame();
        @(posedge aclk);
        #1;

        // Randomized frames: lengths, corruptions, keep errors, occasional clear
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                d = 32'hAAAAAA00 | 32'(i % 256);
                if ($urandom_range(0, 19) == 0) d = d ^ (32'h1 << $urandom_range(0, 31));
                k = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
                beat(d, (i == len - 1), k, ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
        end
        settle();
        expect_counts("random", m_good, m_bad, m_ed, m_el, m_ek, m_err);

        // Throttled instance: 100 frames with random valid gaps
        en0 = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        sel = 1'b1;
        zero_counts();
        new_frame();
        chk_lfsr = 1'b1;
        en1 = 1'b1;
        @(posedge aclk);
        #1;
        for (int f = 0; f < 100; f++) send_frame(16, -1, 0, -1, 4'hF, 0, 1);
        settle();
        chk_lfsr = 1'b0;
        expect_counts("throttle", 100, 0, 0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/axis_chk32.md
# axis_chk32

AXI-Stream sink and checker for the 32-bit loopback test path. It receives frames from the MM2S side of the DMA and checks every beat against the fixed counting pattern that the S2MM-side generator produces: word n of a frame equals {8'hAA, 8'hAA, 8'hAA, n[7:0]}, with TLAST on word WORDS_PER_BLOCK-1. It counts good frames, bad frames and per-class beat errors, and keeps a sticky error flag for software to read through register glue. Optional pseudo-random TREADY throttling exercises DMA backpressure.

## Interface
Parameters:
- BYTES_PER_BLOCK, 64, frame length in bytes; multiple of 4, range 4..1024; WORDS_PER_BLOCK = BYTES_PER_BLOCK/4.
- CNT_W, 16, width of each error/frame counter (8..32).
- THROTTLE, 0, 0 = TREADY high whenever enabled; 1 = TREADY gated by LFSR.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; **synchronous, active-low; clock aclk.**
- en  in  1  1 = MM2S channel running (mm2s_prmry_resetn); 0 = sink idle.
- clear  in  1  synchronous pulse; zeroes all counters and the sticky flag.
- s_tdata  in  32  stream data.
- s_tvalid  in  1  stream valid.
- s_tready  out  1  stream ready.
- s_tlast  in  1  end of frame.
- s_tkeep  in  4  byte enables; must be 4'hF.
- good_frames  out  CNT_W  frames completed with no error.
- bad_frames  out  CNT_W  frames completed with at least one error.
- err_data  out  CNT_W  beats with a data mismatch.
- err_last  out  CNT_W  TLAST position errors (early TLAST or missing TLAST).
- err_keep  out  CNT_W  beats with tkeep != 4'hF.
- error  out  1  sticky; set by any counted error.
- busy  out  1  high while inside a frame (after the first beat, before the TLAST beat).

## Operation
- Handshake: hs = s_tvalid & s_tready. All checks are evaluated only on hs.
- States:
  - OFF: entered when en = 0; beat index = 0.
  - SOF: waiting for the first beat of a frame.
  - BODY: inside a frame.
- State transitions:
  - OFF -> SOF when en = 1.
  - SOF -> BODY on hs with s_tlast = 0.
  - BODY -> SOF on hs with s_tlast = 1.
  - A SOF beat with s_tlast = 1 completes a frame immediately and stays in SOF.
- Beat index: 16 bits; 0 at SOF; incremented on each non-last hs; saturates at 16'hFFFF. The expected data uses index[7:0], so it wraps at 256.
- Per-beat checks on hs:
  - data: s_tdata != {24'hAAAAAA, index[7:0]} -> err_data++.
  - keep: s_tkeep != 4'hF -> err_keep++.
  - last, early: s_tlast = 1 with index < WORDS_PER_BLOCK-1 -> err_last++.
  - last, missing: s_tlast = 0 at index = WORDS_PER_BLOCK-1 -> err_last++, counted once per frame. Checking continues until TLAST arrives; an overlong frame does not add further err_last.
- Frame error flag: cleared at each frame start; set by any beat error in the frame. On the TLAST beat, exactly one of good_frames / bad_frames increments, using the flag combined with the current beat's errors.
- Counters saturate at all-ones, never wrap. error is set on any increment of err_data, err_last or err_keep.
- clear:
  - Zeroes all counters and error.
  - When clear coincides with hs, clear wins and that beat's counter increments are discarded.
  - State and beat index are unaffected.
- en falling mid-frame:
  - Next state is OFF, and a partial frame is dropped without being counted.
  - Counters are held.
- Throttle (THROTTLE=1):
  - 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1.
  - Advances every cycle while en = 1; reloads the seed while in OFF.
  - s_tready = (state != OFF) & (lfsr[0] | lfsr[1]), giving about 75% ready.

## Timing
- Reset values: s_tready 0, all counters 0, error 0, busy 0, state OFF, LFSR 16'hACE1.
- s_tready is driven from registered state/LFSR only; there is no combinational path from s_tvalid.
- With THROTTLE=0, s_tready rises 1 cycle after en rises and falls 1 cycle after en falls.
- Counters, error and busy update 1 cycle after the hs edge.
- Throughput with THROTTLE=0 is one beat per cycle, with no bubbles between frames.

## Structure
- Shared package axis_test_pkg:
  - pattern constant PAT_HI = 24'hAAAAAA;
  - function expected_word(idx);
  - state enum {OFF, SOF, BODY};
  - LFSR seed and taps constants.
- One natural sub-module, sat_counter, parameterised by width, with inc and clr inputs. It is instantiated five times.

## Test plan
- Ideal stream: en = 1, 3 frames of 16 beats of the correct pattern with valid held high. Required: good_frames = 3, all error counters 0, error = 0, s_tready never low.
- Data error: word 5 of frame 1 = 32'hAAAAAA00. Required: err_data = 1, bad_frames = 1, good_frames for the other 2 frames = 2, error = 1.
- Early and missing TLAST: TLAST on beat 7; next frame has no TLAST until beat 20. Required: err_last = 2, bad_frames = 2, and the next correct frame counts as good.
- Keep plus clear: tkeep = 4'h7 on one beat -> err_keep = 1. Then pulse clear on the same cycle as a bad beat. Required: all counters 0 and error = 0.
- Reset and en mid-frame: drop en at beat 8, then raise it and send a full frame. Required: the partial frame is uncounted and good_frames = 1. Asserting aresetn low mid-frame returns all outputs to their reset values.
- THROTTLE=1 with 100 frames and random tvalid gaps. Required: good_frames = 100, zero errors, and the s_tready sequence matches the LFSR model.
